// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the up/down counter core.
package counter_pkg;

  localparam logic [3:0] DOT_ON_D1 = 4'b1101;
  localparam logic [3:0] DOT_OFF   = 4'b1111;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    if (tick_hz == 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned div_width(input int unsigned div);
    if (div < 2) return 1;
    return $clog2(div);
  endfunction

  function automatic bit params_ok(input int unsigned clk_hz, input int unsigned tick_hz,
                                   input int unsigned width, input int unsigned max_count);
    if (tick_hz == 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    if ((clk_hz / tick_hz) < 2) return 1'b0;
    if (width < 1 || width > 32) return 1'b0;
    if (64'(max_count) >= (64'(1) << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles; restart zeroes the phase.
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = div_width(DIV);
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] div_cnt;

  assign tick = en && (div_cnt == Last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (restart) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_gen.sv
// Up/down event counter with prescaled tick, load/clear, wrap or saturate limits,
// terminal-count pulse and decimal-point driver.
module updown_counter_gen
  import counter_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned MAX_COUNT = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             up_down,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [3:0]       dot_data
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [WIDTH-1:0] Max = WIDTH'(MAX_COUNT);

  generate
    if (!params_ok(CLK_HZ, TICK_HZ, WIDTH, MAX_COUNT)) begin : g_bad_params
      $error("updown_counter_gen: illegal CLK_HZ/TICK_HZ/WIDTH/MAX_COUNT combination");
    end
  endgenerate

  logic tick;
  logic restart;

  assign restart = clear | load;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .restart(restart),
    .tick   (tick)
  );

  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             at_limit;

  always_comb begin
    count_d  = count;
    tc_d     = 1'b0;
    at_limit = up_down ? (count == Max) : (count == '0);
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > Max) ? Max : load_value;
    end else if (tick) begin
      tc_d = at_limit;
      if (at_limit) begin
        // Saturate simply holds the pinned value.
        count_d = wrap ? (up_down ? '0 : Max) : count;
      end else begin
        count_d = up_down ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
    end
  end

  always_comb begin
    dot_data = DOT_OFF;
    if (!mode && ((32'(count) % 32'd10) < 32'd5)) dot_data = DOT_ON_D1;
  end

endmodule
